// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Writeback-port arbiter for UNITS execution units sharing one register-file
// write port. Requests, grants and acks are active-low. The grant (wb_ack_,
// grant_e_, grant_rd) is combinational in the request cycle; wb_sel/wb_sel_e_
// are registered so the selected unit writes back in the following cycle.
//
// Build option: define WB_ARB_RR_EN for rotating priority with a per-unit
// starvation guard (4-bit saturating wait counters, a waiter at 15 wins
// outright). Without the macro, arbitration is fixed priority (unit 0
// highest) and the pointer / wait counters are not built. Ports are the
// same in both builds.
//
// RF_W is the width of a register-file index (the RegFile_t payload).
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int UNITS = 4,
  parameter int SEL   = $clog2(UNITS),
  parameter int RF_W  = 5
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic                       flush_,
  input  logic                       wb_stall_,
  input  logic [UNITS-1:0]           wb_req_,
  input  logic [UNITS-1:0][RF_W-1:0] pre_wb_rd,
  output logic [UNITS-1:0]           wb_ack_,
  output logic                       grant_e_,
  output logic [RF_W-1:0]            grant_rd,
  output logic [SEL-1:0]             wb_sel,
  output logic                       wb_sel_e_,
  output logic                       busy
);

  // Expand a unit index into a one-hot vector.
  function automatic logic [UNITS-1:0] idx_to_onehot(input logic [SEL-1:0] idx);
    logic [UNITS-1:0] oh;
    oh = '0;
    for (int i = 0; i < UNITS; i++) begin
      oh[i] = (idx == SEL'(i)) ? 1'b1 : 1'b0;
    end
    return oh;
  endfunction

  // Active-high view of the request vector.
  logic [UNITS-1:0] req_s;
  // Winner of this cycle's arbitration, before flush/stall/reset qualification.
  logic [SEL-1:0]   pick_idx_s;
  logic             pick_valid_s;
  // Qualified grant and its one-hot form.
  logic             grant_s;
  logic [UNITS-1:0] gnt_vec_s;
  // Registered writeback select for the cycle after the grant.
  logic [SEL-1:0]   wb_sel_r;
  logic             wb_sel_e_r;

`ifdef WB_ARB_RR_EN
  localparam logic [SEL:0] UNITS_W = (SEL+1)'(UNITS);
  localparam logic [3:0]   WAIT_MAX = 4'd15;

  // Rotating priority pointer: the first index searched next cycle.
  logic [SEL-1:0]        ptr_r;
  // Per-unit count of cycles spent requesting without a grant.
  logic [UNITS-1:0][3:0] wait_cnt_r;
  // Units whose wait counter has saturated.
  logic [UNITS-1:0]      starve_s;
  // Search position (ptr + offset) before the modulo wrap.
  logic [SEL:0]          pos_s;

  // Pointer increment modulo UNITS (UNITS need not be a power of two).
  function automatic logic [SEL-1:0] next_ptr(input logic [SEL-1:0] idx);
    logic [SEL:0] nxt;
    nxt = {1'b0, idx} + {{SEL{1'b0}}, 1'b1};
    return (nxt >= UNITS_W) ? '0 : nxt[SEL-1:0];
  endfunction

  // Pick a winner: saturated waiters first (lowest index), otherwise search upward from ptr.
  always_comb begin
    req_s        = ~wb_req_;
    pick_idx_s   = '0;
    pick_valid_s = |req_s;
    pos_s        = '0;
    starve_s     = '0;
    for (int i = 0; i < UNITS; i++) begin
      starve_s[i] = req_s[i] & (wait_cnt_r[i] == WAIT_MAX);
    end
    if (|starve_s) begin
      // Descending scan so the lowest starving index is written last.
      for (int i = UNITS - 1; i >= 0; i--) begin
        pick_idx_s = starve_s[i] ? SEL'(i) : pick_idx_s;
      end
    end else begin
      // Descending offset scan so the closest requester at or after ptr wins.
      for (int k = UNITS - 1; k >= 0; k--) begin
        pos_s      = {1'b0, ptr_r} + (SEL+1)'(k);
        pos_s      = (pos_s >= UNITS_W) ? (pos_s - UNITS_W) : pos_s;
        pick_idx_s = req_s[pos_s[SEL-1:0]] ? pos_s[SEL-1:0] : pick_idx_s;
      end
    end
  end

  // Advance the pointer past each granted unit; flush and idle cycles leave it alone.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ptr_r <= '0;
    end else if (grant_s) begin
      ptr_r <= next_ptr(pick_idx_s);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Age waiting requesters; a grant clears its own counter, a flush clears all.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wait_cnt_r <= '0;
    end else if (!flush_) begin
      wait_cnt_r <= '0;
    end else begin
      for (int i = 0; i < UNITS; i++) begin
        if (gnt_vec_s[i]) begin
          wait_cnt_r[i] <= 4'd0;
        end else if (req_s[i] && (wait_cnt_r[i] != WAIT_MAX)) begin
          wait_cnt_r[i] <= wait_cnt_r[i] + 4'd1;
        end else begin
          wait_cnt_r[i] <= wait_cnt_r[i];
        end
      end
    end
  end
`else
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    req_s        = ~wb_req_;
    pick_idx_s   = '0;
    pick_valid_s = |req_s;
    // Descending scan so the lowest requesting index is written last.
    for (int i = UNITS - 1; i >= 0; i--) begin
      pick_idx_s = req_s[i] ? SEL'(i) : pick_idx_s;
    end
  end
`endif

  // Qualify the winner: nothing is granted under reset, flush or a busy write port.
  always_comb begin
    grant_s   = reset_ & flush_ & wb_stall_ & pick_valid_s;
    gnt_vec_s = grant_s ? idx_to_onehot(pick_idx_s) : '0;
  end

  // Capture this cycle's grant as next cycle's writeback select.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wb_sel_r   <= '0;
      wb_sel_e_r <= 1'b1;
    end else if (grant_s) begin
      wb_sel_r   <= pick_idx_s;
      wb_sel_e_r <= 1'b0;
    end else begin
      wb_sel_r   <= wb_sel_r;
      wb_sel_e_r <= 1'b1;
    end
  end

  // Grant-cycle outputs are combinational; a flush in the writeback cycle cancels it.
  always_comb begin
    wb_ack_   = ~gnt_vec_s;
    grant_e_  = ~grant_s;
    grant_rd  = grant_s ? pre_wb_rd[pick_idx_s] : '0;
    busy      = reset_ & (|req_s) & ~grant_s;
    wb_sel    = wb_sel_r;
    wb_sel_e_ = wb_sel_e_r | ~flush_;
  end

endmodule
